// File: rtl/seq_arith_unit.sv
// seq_arith_unit: multi-cycle unsigned add/sub/mul/div behind valid/ready channels.
// Ports: clk, rst_n, in_valid/in_ready + a, b, op_sel (00 add, 01 sub, 10 mul,
//   11 div); out_valid/out_ready + result, remainder, overflow; busy (CALC or DONE).
module seq_arith_unit #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       op_sel,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] remainder,
    output logic             overflow,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]         state;
    logic [1:0]         op_q;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic [2*WIDTH-1:0] acc;
    logic [CW-1:0]      cnt;

    logic [WIDTH:0]     addsub;
    logic [WIDTH-1:0]   mul_add;
    logic [WIDTH:0]     msum;
    logic [2*WIDTH-1:0] mul_nxt;
    logic [WIDTH:0]     dshift;
    logic [WIDTH:0]     ddiff;
    logic               dge;
    logic [2*WIDTH-1:0] div_nxt;
    logic [2*WIDTH-1:0] acc_nxt;
    logic               last;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);

    // Top bit of the WIDTH+1 result is the carry (add) or borrow (sub).
    assign addsub = op_q[0] ? ({1'b0, a_q} - {1'b0, b_q})
                            : ({1'b0, a_q} + {1'b0, b_q});

    // Multiply: acc = {partial product, remaining multiplier bits}.
    // Add A when the multiplier LSB is set, then shift the whole pair right.
    assign mul_add = acc[0] ? a_q : '0;
    assign msum    = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, mul_add};
    assign mul_nxt = {msum, acc[WIDTH-1:1]};

    // Divide: acc = {partial remainder, dividend shifting into quotient}.
    // Shifted remainder is < 2*B, so WIDTH+1 bits hold it without loss.
    assign dshift  = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    assign dge     = (dshift >= {1'b0, b_q});
    assign ddiff   = dshift - {1'b0, b_q};
    assign div_nxt = dge ? {ddiff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1}
                         : {dshift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};

    assign acc_nxt = op_q[0] ? div_nxt : mul_nxt;
    assign last    = (cnt == CW'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            op_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            acc       <= '0;
            cnt       <= '0;
            result    <= '0;
            remainder <= '0;
            overflow  <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        op_q <= op_sel;
                        a_q  <= a;
                        b_q  <= b;
                        cnt  <= op_sel[1] ? CW'(WIDTH) : CW'(1);
                        if (op_sel == 2'b10) begin
                            acc <= {{WIDTH{1'b0}}, b};
                        end else begin
                            acc <= {{WIDTH{1'b0}}, a};
                        end
                        // Divide-by-zero needs no iterations.
                        if (op_sel == 2'b11 && b == '0) begin
                            state     <= DONE;
                            result    <= '0;
                            remainder <= '0;
                            overflow  <= 1'b1;
                        end else begin
                            state <= CALC;
                        end
                    end
                end
                CALC: begin
                    cnt <= cnt - CW'(1);
                    if (op_q[1]) begin
                        acc <= acc_nxt;
                    end
                    if (last) begin
                        state <= DONE;
                        if (!op_q[1]) begin
                            result    <= addsub[WIDTH-1:0];
                            remainder <= '0;
                            overflow  <= addsub[WIDTH];
                        end else if (op_q[0]) begin
                            result    <= acc_nxt[WIDTH-1:0];
                            remainder <= acc_nxt[2*WIDTH-1:WIDTH];
                            overflow  <= 1'b0;
                        end else begin
                            result    <= acc_nxt[WIDTH-1:0];
                            remainder <= '0;
                            overflow  <= |acc_nxt[2*WIDTH-1:WIDTH];
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_arith_unit.sv
// tb_seq_arith_unit: randomized and directed checks of seq_arith_unit
// against a cycle-level behavioural model of the handshakes and arithmetic.
module tb_seq_arith_unit;

    localparam int W = 4;
    localparam int M = 1 << W;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic [1:0]   op_sel = '0;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic [W-1:0] remainder;
    logic         overflow;
    logic         busy;

    seq_arith_unit #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .op_sel(op_sel),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .remainder(remainder),
        .overflow(overflow), .busy(busy)
    );

    always #5 clk = ~clk;

    int     n_chk = 0;
    int     n_fail = 0;
    longint cyc = 0;
    bit     rand_rdy = 1'b0;
    bit     fixed_rdy = 1'b1;
    bit     vexp;

    typedef struct {
        int     res;
        int     rem;
        int     ovf;
        longint due;
    } exp_t;

    exp_t q[$];

    // Arithmetic from plain integer math; 'due' is the last edge count
    // before which out_valid must still be low.
    function automatic exp_t model(int x, int y, int op, longint t);
        exp_t e;
        int   lat;
        e.rem = 0;
        case (op)
            0: begin
                e.res = (x + y) % M; e.ovf = int'(x + y >= M); lat = 2;
            end
            1: begin
                e.res = (x - y + M) % M; e.ovf = int'(x < y); lat = 2;
            end
            2: begin
                e.res = (x * y) % M; e.ovf = int'(x * y >= M); lat = W + 1;
            end
            default: begin
                if (y == 0) begin
                    e.res = 0; e.ovf = 1; lat = 1;
                end else begin
                    e.res = x / y; e.rem = x % y; e.ovf = 0; lat = W + 1;
                end
            end
        endcase
        e.due = t + longint'(lat) - 1;
        return e;
    endfunction

    task automatic chk(string nm, longint act, longint exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        cyc <= cyc + 1;
    end

    always @(posedge clk) begin
        #1;
        out_ready = rand_rdy ? 1'($urandom % 2) : fixed_rdy;
    end

    // Per-cycle compare against the model.
    always @(negedge clk) begin
        if (!rst_n) begin
            q.delete();
            chk("rst_in_ready", longint'(in_ready), 1);
            chk("rst_out_valid", longint'(out_valid), 0);
            chk("rst_busy", longint'(busy), 0);
            chk("rst_result", longint'(result), 0);
            chk("rst_remainder", longint'(remainder), 0);
            chk("rst_overflow", longint'(overflow), 0);
        end else begin
            vexp = (q.size() > 0) && (cyc >= q[0].due);
            chk("in_ready", longint'(in_ready), longint'(q.size() == 0));
            chk("busy", longint'(busy), longint'(q.size() > 0));
            chk("out_valid", longint'(out_valid), longint'(vexp));
            if (vexp && out_valid) begin
                chk("result", longint'(result), longint'(q[0].res));
                chk("remainder", longint'(remainder), longint'(q[0].rem));
                chk("overflow", longint'(overflow), longint'(q[0].ovf));
                if (out_ready) q.pop_front();
            end
            if (in_valid && in_ready) begin
                q.push_back(model(int'(a), int'(b), int'(op_sel), cyc + 1));
            end
        end
    end

    task automatic send(int x, int y, int op);
        int g;
        g = 0;
        @(posedge clk);
        #1;
        a = W'(x); b = W'(y); op_sel = 2'(op); in_valid = 1'b1;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            g++;
            if (g > 200) begin
                chk("send_timeout", 0, 1);
                break;
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a = W'($urandom); b = W'($urandom); op_sel = 2'($urandom);
    endtask

    task automatic wait_out(output int n);
        n = 1;
        forever begin
            @(negedge clk);
            if (out_valid) break;
            n++;
            if (n > 100) begin
                chk("wait_out_timeout", 0, 1);
                break;
            end
        end
    endtask

    task automatic dir(string nm, int x, int y, int op,
                       int er, int erem, int eovf, int elat);
        int n;
        send(x, y, op);
        wait_out(n);
        chk({nm, "_lat"}, longint'(n), longint'(elat));
        chk({nm, "_res"}, longint'(result), longint'(er));
        chk({nm, "_rem"}, longint'(remainder), longint'(erem));
        chk({nm, "_ovf"}, longint'(overflow), longint'(eovf));
    endtask

    initial begin
        int n;
        int g;
        fixed_rdy = 1'b1;
        repeat (3) @(negedge clk);
        #2;
        rst_n = 1'b1;

        dir("add_9_8", 9, 8, 0, 1, 0, 1, 2);
        @(negedge clk);
        chk("add_valid_one_cycle", longint'(out_valid), 0);
        chk("add_in_ready_t3", longint'(in_ready), 1);

        dir("sub_3_5", 3, 5, 1, 14, 0, 1, 2);
        dir("sub_5_3", 5, 3, 1, 2, 0, 0, 2);
        dir("mul_5_4", 5, 4, 2, 4, 0, 1, 5);
        dir("mul_3_5", 3, 5, 2, 15, 0, 0, 5);
        dir("mul_15_15", 15, 15, 2, 1, 0, 1, 5);
        dir("div_13_4", 13, 4, 3, 3, 1, 0, 5);
        dir("div_7_0", 7, 0, 3, 0, 0, 1, 1);

        // Backpressure with stray requests during CALC and DONE.
        fixed_rdy = 1'b0;
        repeat (3) @(posedge clk);
        send(9, 2, 3);
        in_valid = 1'b1; a = 4'd1; b = 4'd1; op_sel = 2'd0;
        @(negedge clk);
        chk("bp_calc_in_ready", longint'(in_ready), 0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        wait_out(n);
        chk("bp_res", longint'(result), 4);
        chk("bp_rem", longint'(remainder), 1);
        in_valid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("bp_hold_valid", longint'(out_valid), 1);
            chk("bp_hold_res", longint'(result), 4);
            chk("bp_hold_rem", longint'(remainder), 1);
            chk("bp_done_in_ready", longint'(in_ready), 0);
        end
        in_valid = 1'b0;
        fixed_rdy = 1'b1;
        repeat (5) @(negedge clk);
        chk("bp_no_second", longint'(out_valid), 0);
        chk("bp_idle", longint'(in_ready), 1);

        // Reset in the second CALC cycle of 7x6.
        send(7, 6, 2);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_in_ready", longint'(in_ready), 1);
        chk("mid_rst_valid", longint'(out_valid), 0);
        chk("mid_rst_result", longint'(result), 0);
        chk("mid_rst_rem", longint'(remainder), 0);
        chk("mid_rst_ovf", longint'(overflow), 0);
        chk("mid_rst_busy", longint'(busy), 0);
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_in_ready", longint'(in_ready), 1);
        dir("add_2_2", 2, 2, 0, 4, 0, 0, 2);

        // Random traffic with random backpressure.
        rand_rdy = 1'b1;
        repeat (300) begin
            int x;
            int y;
            x = $urandom_range(0, M - 1);
            y = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(0, M - 1);
            send(x, y, $urandom_range(0, 3));
        end
        rand_rdy = 1'b0;
        fixed_rdy = 1'b1;
        g = 0;
        while (q.size() > 0 && g < 100) begin
            @(negedge clk);
            g++;
        end
        chk("drain", longint'(q.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/seq_arith_unit.md
Name: seq_arith_unit

Overview:
Multi-cycle, handshaked counterpart of the team's 4-bit combinational arithmetic unit, using the same op_sel encoding and overflow semantics. It accepts one operation request on a valid/ready input channel and computes it with registered datapath steps: add/sub in one step, shift-add multiply, restoring divide. It returns the result on a valid/ready output channel. It sits between a command sequencer and the result consumer, where single-cycle multiply/divide does not meet timing.

Parameters:
WIDTH, 4, operand/result width in bits (≥2); also the iteration count for multiply and divide.

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
in_valid  input  1  request valid.
in_ready  output  1  block can accept a request.
a  input  WIDTH  operand A.
b  input  WIDTH  operand B.
op_sel  input  2  operation: 00 add, 01 sub, 10 mul, 11 div.
out_valid  output  1  result valid.
out_ready  input  1  consumer accepts the result.
result  output  WIDTH  operation result.
remainder  output  WIDTH  divide remainder; 0 for other ops.
overflow  output  1  carry / borrow / product-overflow / divide-by-zero flag.
busy  output  1  high in CALC or DONE.

Behaviour:
- Reset (async assert, sync release): state IDLE. in_ready=1. out_valid=0, result=0, remainder=0, overflow=0, busy=0. Internal operand, accumulator and counter registers are cleared.
- States:
  - IDLE: in_ready=1. A handshake (in_valid & in_ready) captures a, b and op_sel into registers.
  - Transition from IDLE on handshake: div with b==0 goes to DONE. Every other op goes to CALC.
  - Counter load on handshake: add/sub load 1; mul/div load WIDTH.
  - CALC: one step per cycle; counter decrements. When the counter reaches 0, the final values are registered into result/remainder/overflow and the state goes to DONE.
  - DONE: out_valid=1; outputs are held stable until out_ready=1. On (out_valid & out_ready) the state goes to IDLE. in_ready is next high the cycle after that. There is no same-cycle turnaround.
- Latency (handshake at edge T): add/sub out_valid from T+2. mul/div out_valid from T+1+WIDTH. Divide-by-zero out_valid from T+1.
- Arithmetic (all unsigned):
  - add: {overflow,result} = A+B, computed at WIDTH+1 bits.
  - sub: {overflow,result} = A−B, computed at WIDTH+1 bits. overflow=1 iff A<B; result wraps modulo 2^WIDTH.
  - mul: shift-add over a 2*WIDTH-bit accumulator, one multiplier bit per step, LSB first. result = product[WIDTH-1:0]. overflow = |product[2*WIDTH-1:WIDTH].
  - div: restoring division, one quotient bit per step, MSB first. result = quotient, remainder = A mod B, overflow=0.
  - div, b==0: result=0, remainder=0, overflow=1.
- Inputs a, b and op_sel are ignored outside the accepting cycle; changes during CALC/DONE have no effect.
- in_valid during CALC/DONE is not accepted (in_ready=0). The requester holds the request.
- out_ready while out_valid=0 has no effect.
- result/remainder/overflow keep their last values after returning to IDLE, until the next completion overwrites them. They are meaningful only while out_valid=1.
- Reset mid-operation aborts immediately to reset values. No partial result is ever presented.
- Counter and accumulator widths are sized from WIDTH. No wrap beyond WIDTH iterations.

Test Plan:
- Add, A=9, B=8, op 00, out_ready=1 -> result=1, overflow=1, out_valid exactly at T+2 for one cycle; in_ready high at T+3.
- Sub, 3−5 -> result=4'hE, overflow=1. Then 5−3 -> result=2, overflow=0.
- Mul: 5×4 -> result=4, overflow=1, out_valid at T+5. 3×5 -> result=15, overflow=0. 15×15 -> result=1, overflow=1.
- Div: 13/4 -> result=3, remainder=1, overflow=0, out_valid at T+5. 7/0 -> result=0, remainder=0, overflow=1, out_valid at T+1.
- Backpressure: out_ready held 0 for 3 cycles after a 9/2 completion -> out_valid, result=4, remainder=1 stable throughout. in_valid pulsed during CALC/DONE is not accepted (in_ready=0, no second result).
- Reset mid-mul: rst_n low during the 2nd CALC cycle of 7×6 -> all outputs return to reset values immediately, in_ready=1 after release. A following 2+2 returns 4, overflow=0.
